// File: rtl/pe_accumulator_pkg.sv
// Shared widths, state encoding and width helpers for the partial-sum accumulator.
// The FIFO and the accumulator top both derive their widths from here.
package pe_accumulator_pkg;

  localparam int unsigned NUM_WIDTH_DEF  = 8;
  localparam int unsigned DATA_BUS       = 16;
  localparam int unsigned PSUM_WIDTH_DEF = DATA_BUS + 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Wide enough that ACC_TERMS full-scale partial sums never wrap.
  function automatic int unsigned acc_width(input int unsigned psum_w, input int unsigned terms);
    return psum_w + $clog2(terms);
  endfunction

  // Extra MSB separates full from empty when the address bits match.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with a combinational head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
  import pe_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam int unsigned ADDR_W = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_write;
  logic             do_read;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  assign do_read  = pop && !empty;
  assign do_write = push && (!full || do_read);

  // Masked while empty so the head reads 0 out of reset.
  assign head_data = empty ? '0 : mem[rptr[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_write) wptr <= wptr + 1'b1;
      if (do_read)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/pe_accumulator.sv
// Sums ACC_TERMS partial sums per element, requantizes by SHIFT with saturation,
// and queues the result in a small FIFO for a valid/ready consumer.
module pe_accumulator
  import pe_accumulator_pkg::*;
#(
  parameter int unsigned NUM_WIDTH  = NUM_WIDTH_DEF,
  parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int unsigned ACC_TERMS  = 4,
  parameter int unsigned SHIFT      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psum_valid,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  overflow,
  output logic                  busy,
  output state_t                fsm_state
);

  // Handshake: an element leaves the head on any rising edge where out_valid
  // and out_ready are both high; the head is held steady until then.

  localparam int unsigned ACC_W = acc_width(PSUM_WIDTH, ACC_TERMS);
  localparam int unsigned CNT_W = $clog2(ACC_TERMS + 1);
  localparam logic [ACC_W-1:0] Q_MAX = ACC_W'({NUM_WIDTH{1'b1}});

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [ACC_W-1:0]   sum_next;
  logic [ACC_W-1:0]   q;
  logic               last_term;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               q_sat;
  logic [NUM_WIDTH:0] push_data;
  logic [NUM_WIDTH:0] head_data;

  assign sum_next  = (state == ACCUM) ? acc + ACC_W'(psum_in) : ACC_W'(psum_in);
  assign last_term = (count == CNT_W'(ACC_TERMS - 1));

  assign q         = sum_next >> SHIFT;
  assign q_sat     = (q > Q_MAX);
  assign push_data = {q_sat, q_sat ? {NUM_WIDTH{1'b1}} : q[NUM_WIDTH-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
    end
  end

  // clear outranks psum_valid, so a term arriving with clear is lost.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    push       = 1'b0;
    if (clear) begin
      state_next = IDLE;
      acc_next   = '0;
      count_next = '0;
    end else if (psum_valid) begin
      if (last_term) begin
        state_next = IDLE;
        acc_next   = '0;
        count_next = '0;
        push       = 1'b1;
      end else begin
        state_next = ACCUM;
        acc_next   = sum_next;
        count_next = count + 1'b1;
      end
    end
  end

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     overflow <= 1'b0;
    else if (push && full && !pop)  overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (NUM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head_data (head_data)
  );

  assign out_valid = !empty;
  assign out_sat   = head_data[NUM_WIDTH];
  assign out_data  = head_data[NUM_WIDTH-1:0];
  assign busy      = (state == ACCUM);
  assign fsm_state = state;

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed bench for pe_accumulator at default parameters: a vector table of
// four-term elements plus hand-written overflow, clear and reset sequences.
module tb_pe_accumulator;
  import pe_accumulator_pkg::*;

  logic        clk;
  logic        reset;
  logic        psum_valid;
  logic [17:0] psum_in;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        overflow;
  logic        busy;
  state_t      fsm_state;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0][17:0] t;
    logic [7:0]       data;
    logic             sat;
  } vec_t;

  vec_t vecs[9];

  pe_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .overflow   (overflow),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    psum_valid = 1'b0;
    psum_in    = '0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drivers
  task automatic feed(input logic [17:0] v);
    psum_valid = 1'b1;
    psum_in    = v;
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic element(input logic [17:0] v);
    for (int i = 0; i < 4; i++) feed(v);
  endtask

  // scoreboard drain, bounded by a cycle budget
  task automatic drain(input int expect_n);
    int n;
    n = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (!out_valid) break;
      if (exp_q.size() == 0) check("drain_extra", 1, 0);
      else check("drain_data", out_data, exp_q.pop_front());
      n++;
      tick();
    end
    out_ready = 1'b0;
    check("drain_count", n, expect_n);
    check("drain_empty", out_valid, 0);
  endtask

  initial begin
    vecs[0] = '{t: {18'd400, 18'd300, 18'd200, 18'd100}, data: 8'd62,  sat: 1'b0};
    vecs[1] = '{t: {18'd4095, 18'd4095, 18'd4095, 18'd4095}, data: 8'd255, sat: 1'b1};
    vecs[2] = '{t: {18'd0, 18'd0, 18'd0, 18'd0}, data: 8'd0, sat: 1'b0};
    vecs[3] = '{t: {18'd0, 18'd0, 18'd0, 18'd15}, data: 8'd0, sat: 1'b0};
    vecs[4] = '{t: {18'd16, 18'd16, 18'd16, 18'd16}, data: 8'd4, sat: 1'b0};
    vecs[5] = '{t: {18'd1023, 18'd1023, 18'd1023, 18'd1023}, data: 8'd255, sat: 1'b0};
    vecs[6] = '{t: {18'd1024, 18'd1024, 18'd1024, 18'd1024}, data: 8'd255, sat: 1'b1};
    vecs[7] = '{t: {18'd262143, 18'd262143, 18'd262143, 18'd262143}, data: 8'd255, sat: 1'b1};
    vecs[8] = '{t: {18'd1, 18'd2, 18'd3, 18'd4090}, data: 8'd255, sat: 1'b1};

    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", out_sat, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);

    // table: four consecutive terms, result visible right after the last edge
    out_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 4; i++) begin
        feed(vecs[v].t[i]);
        if (i < 3) check("vec_busy", busy, 1);
      end
      check("vec_valid", out_valid, 1);
      check("vec_data", out_data, vecs[v].data);
      check("vec_sat", out_sat, vecs[v].sat);
      check("vec_idle", busy, 0);
      tick();
      check("vec_popped", out_valid, 0);
    end

    // gaps between terms hold the partial sum: 50+50+60+80 = 240 -> 15
    feed(18'd50); tick();
    check("gap_busy", busy, 1);
    feed(18'd50); tick(); tick();
    feed(18'd60); tick();
    check("gap_no_out", out_valid, 0);
    feed(18'd80);
    check("gap_data", out_data, 15);
    tick();

    // overflow: fifth element dropped while the consumer stalls
    do_reset();
    for (int e = 0; e < 4; e++) begin
      element(18'd4);
      exp_q.push_back(8'd1);
    end
    check("ovf_not_yet", overflow, 0);
    element(18'd4);
    check("ovf_set", overflow, 1);
    check("ovf_busy", busy, 0);
    drain(4);
    element(18'd16);
    check("ovf_sticky", overflow, 1);
    tick();

    // full FIFO, final term coincides with a pop: no drop
    do_reset();
    for (int e = 1; e <= 4; e++) element(18'(4 * e));
    tick();
    check("full_head_stable", out_data, 1);
    for (int i = 0; i < 3; i++) feed(18'd20);
    out_ready = 1'b1;
    feed(18'd20);
    out_ready = 1'b0;
    check("full_no_ovf", overflow, 0);
    check("full_head", out_data, 2);
    exp_q = '{8'd2, 8'd3, 8'd4, 8'd5};
    drain(4);

    // clear with a same-cycle term discards everything held
    do_reset();
    feed(18'd16);
    feed(18'd16);
    clear = 1'b1;
    feed(18'd16);
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_no_out", out_valid, 0);
    element(18'd16);
    check("clr_valid", out_valid, 1);
    check("clr_data", out_data, 4);

    // asynchronous reset mid-element with two queued entries
    do_reset();
    element(18'd16);
    element(18'd16);
    feed(18'd32);
    feed(18'd32);
    check("arst_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_sat", out_sat, 0);
    check("arst_busy", busy, 0);
    check("arst_overflow", overflow, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    element(18'd32);
    check("arst_new_valid", out_valid, 1);
    check("arst_new_data", out_data, 8);
    tick();
    check("arst_only_one", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
